// File: rtl/ssp_frame_master.sv
// ssp_frame_master: serializes one register request into a 16-bit SPI mode-0 frame and captures read data.
// Latency: accept at edge 0, SSEL high cycles 1..33*CLK_DIV, Done/Rsp_Valid pulse in cycle 33*CLK_DIV+1.
// Backpressure: Req_Ready is low while a frame is in flight; requests seen then are ignored, never queued.
module ssp_frame_master #(
   parameter int CLK_DIV = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [2:0]  Req_RA,
   input  logic        Req_WnR,
   input  logic [11:0] Req_DI,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   output logic [11:0] Rsp_DO,
   output logic        Rsp_Valid,
   output logic        Done,
   output logic        SSP_SSEL,
   output logic        SSP_SCK,
   output logic        SSP_MOSI,
   input  logic        SSP_MISO
);

   typedef enum logic [1:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_DONE} state_t;

   // Terminal value of the half-period counter.
   localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

   state_t      state;
   logic [7:0]  hcnt;     // clocks elapsed in the current half period
   logic [3:0]  bcnt;     // bits remaining, 15 down to 0
   logic [14:0] tx;       // frame bits still to send after the one on MOSI
   logic [11:0] rx;       // last 12 MISO samples; older bits fall off the top
   logic        wnr;      // captured write flag, decides Rsp_Valid

   // Frame sequencer: all outputs are registered and change only here.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= ST_IDLE;
         hcnt      <= 8'd0;
         bcnt      <= 4'd0;
         tx        <= 15'd0;
         rx        <= 12'd0;
         wnr       <= 1'b0;
         Req_Ready <= 1'b1;
         Rsp_DO    <= 12'd0;
         Rsp_Valid <= 1'b0;
         Done      <= 1'b0;
         SSP_SSEL  <= 1'b0;
         SSP_SCK   <= 1'b0;
         SSP_MOSI  <= 1'b0;
      end else begin
         Done      <= 1'b0;
         Rsp_Valid <= 1'b0;
         case (state)
            // DONE behaves like IDLE for accepting, so frames can run back-to-back.
            ST_IDLE, ST_DONE: begin
               SSP_SSEL  <= 1'b0;
               SSP_SCK   <= 1'b0;
               SSP_MOSI  <= 1'b0;
               Req_Ready <= 1'b1;
               state     <= ST_IDLE;
               if (Req_Valid) begin
                  // MSB goes straight onto MOSI; the rest waits in tx.
                  tx        <= {Req_RA[1:0], Req_WnR, Req_DI};
                  wnr       <= Req_WnR;
                  SSP_MOSI  <= Req_RA[2];
                  SSP_SSEL  <= 1'b1;
                  Req_Ready <= 1'b0;
                  hcnt      <= 8'd0;
                  state     <= ST_LEAD;
               end
            end
            ST_LEAD: begin
               if (hcnt == HMAX) begin
                  hcnt    <= 8'd0;
                  bcnt    <= 4'd15;
                  SSP_SCK <= 1'b1;
                  state   <= ST_SHIFT;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (hcnt != HMAX) begin
                  hcnt <= hcnt + 8'd1;
               end else if (SSP_SCK) begin
                  // End of high phase: sample MISO, present next bit (zeros after the last).
                  hcnt     <= 8'd0;
                  SSP_SCK  <= 1'b0;
                  rx       <= {rx[10:0], SSP_MISO};
                  SSP_MOSI <= tx[14];
                  tx       <= {tx[13:0], 1'b0};
               end else if (bcnt == 4'd0) begin
                  // End of the final low phase: close the frame and publish read data.
                  hcnt      <= 8'd0;
                  SSP_SSEL  <= 1'b0;
                  SSP_MOSI  <= 1'b0;
                  Done      <= 1'b1;
                  Rsp_Valid <= ~wnr;
                  Rsp_DO    <= rx;
                  Req_Ready <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  hcnt    <= 8'd0;
                  bcnt    <= bcnt - 4'd1;
                  SSP_SCK <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ssp_frame_master.sv
// Bench for ssp_frame_master: two instances (CLK_DIV=2 and CLK_DIV=1) driven by directed and random frames.
// Expected frames come from a frame-level model: MOSI word, SSEL length, Done cycle and read data by arithmetic.
module tb_ssp_frame_master;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_ra;
   logic        req_wnr;
   logic [11:0] req_di;
   logic        req_valid;
   logic        use_b;
   logic        miso;

   logic        vld_a, vld_b;
   logic        a_ready, a_rv, a_done, a_ssel, a_sck, a_mosi;
   logic        b_ready, b_rv, b_done, b_ssel, b_sck, b_mosi;
   logic [11:0] a_rsp, b_rsp;

   logic        o_ready, o_rv, o_done, o_ssel, o_sck, o_mosi;
   logic [11:0] o_rsp;

   int vectors = 0;
   int miscompares = 0;

   // Frame observations gathered by run_frame.
   logic [15:0] r_mosi;
   logic [11:0] r_rsp;
   int r_ssel_cycles, r_done_cyc, r_rv_cnt, r_rises, r_first_rise, r_period_bad, r_ready_busy;
   logic r_rv_at_done, r_ssel_first, r_ssel_at_done, r_ready_at_done;

   always #5 clk = ~clk;

   assign vld_a = req_valid & ~use_b;
   assign vld_b = req_valid & use_b;

   assign o_ready = use_b ? b_ready : a_ready;
   assign o_rv    = use_b ? b_rv    : a_rv;
   assign o_done  = use_b ? b_done  : a_done;
   assign o_ssel  = use_b ? b_ssel  : a_ssel;
   assign o_sck   = use_b ? b_sck   : a_sck;
   assign o_mosi  = use_b ? b_mosi  : a_mosi;
   assign o_rsp   = use_b ? b_rsp   : a_rsp;

   ssp_frame_master #(.CLK_DIV(2)) dut_a (
      .Clk(clk), .Rst(rst), .Req_RA(req_ra), .Req_WnR(req_wnr), .Req_DI(req_di),
      .Req_Valid(vld_a), .Req_Ready(a_ready), .Rsp_DO(a_rsp), .Rsp_Valid(a_rv),
      .Done(a_done), .SSP_SSEL(a_ssel), .SSP_SCK(a_sck), .SSP_MOSI(a_mosi), .SSP_MISO(miso)
   );

   ssp_frame_master #(.CLK_DIV(1)) dut_b (
      .Clk(clk), .Rst(rst), .Req_RA(req_ra), .Req_WnR(req_wnr), .Req_DI(req_di),
      .Req_Valid(vld_b), .Req_Ready(b_ready), .Rsp_DO(b_rsp), .Rsp_Valid(b_rv),
      .Done(b_done), .SSP_SSEL(b_ssel), .SSP_SCK(b_sck), .SSP_MOSI(b_mosi), .SSP_MISO(miso)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request from a negedge and follows the frame until Done or the cycle budget runs out.
   // Acts as the slave too: on each SCK rise it puts the next bit of mw on MISO.
   task automatic run_frame(input int d, input logic [2:0] ra, input logic wnr, input logic [11:0] di,
                            input logic [15:0] mw, input bit hold, input bit poke);
      bit fin = 0;
      logic prev_sck = 1'b0;
      int last_rise = 0;
      req_ra = ra; req_wnr = wnr; req_di = di; req_valid = 1'b1; miso = 1'b0;
      r_mosi = 16'd0; r_rsp = 12'd0; r_ssel_cycles = 0; r_done_cyc = 0; r_rv_cnt = 0;
      r_rises = 0; r_first_rise = 0; r_period_bad = 0; r_ready_busy = 0;
      r_rv_at_done = 1'b0; r_ssel_first = 1'b0; r_ssel_at_done = 1'b1; r_ready_at_done = 1'b0;
      for (int c = 1; c <= 33 * d + 8 && !fin; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) req_valid = 1'b0;
         if (poke && c == 8) begin
            req_valid = 1'b1; req_di = ~di; req_ra = ~ra; req_wnr = ~wnr;
         end
         if (poke && c == 20) req_valid = 1'b0;
         if (c == 1) r_ssel_first = o_ssel;
         if (o_ssel) r_ssel_cycles++;
         if (o_rv) r_rv_cnt++;
         if (o_sck && !prev_sck) begin
            r_mosi = {r_mosi[14:0], o_mosi};
            if (r_rises == 0) r_first_rise = c;
            else if (c - last_rise != 2 * d) r_period_bad++;
            last_rise = c;
            if (r_rises < 16) miso = mw[15 - r_rises];
            r_rises++;
         end
         prev_sck = o_sck;
         if (o_done) begin
            fin = 1;
            r_done_cyc = c;
            r_rv_at_done = o_rv;
            r_rsp = o_rsp;
            r_ssel_at_done = o_ssel;
            r_ready_at_done = o_ready;
         end else if (o_ready) begin
            r_ready_busy++;
         end
      end
   endtask

   // Frame-level reference: what a correct master must have shown for this request.
   task automatic check_frame(input string tag, input int d, input logic [2:0] ra, input logic wnr,
                              input logic [11:0] di, input logic [15:0] mw);
      logic [15:0] exp_word;
      exp_word = {ra, wnr, di};
      chk({tag, ".mosi"},       r_mosi, exp_word);
      chk({tag, ".rises"},      r_rises, 16);
      chk({tag, ".first_rise"}, r_first_rise, d + 1);
      chk({tag, ".sck_period"}, r_period_bad, 0);
      chk({tag, ".ssel_len"},   r_ssel_cycles, 33 * d);
      chk({tag, ".ssel_first"}, r_ssel_first, 1);
      chk({tag, ".done_cyc"},   r_done_cyc, 33 * d + 1);
      chk({tag, ".ssel_done"},  r_ssel_at_done, 0);
      chk({tag, ".ready_busy"}, r_ready_busy, 0);
      chk({tag, ".ready_done"}, r_ready_at_done, 1);
      chk({tag, ".rv_count"},   r_rv_cnt, wnr ? 0 : 1);
      chk({tag, ".rv_at_done"}, r_rv_at_done, !wnr);
      chk({tag, ".rsp_do"},     r_rsp, mw[11:0]);
   endtask

   initial begin
      logic [2:0]  ra;
      logic        wnr;
      logic [11:0] di;
      logic [15:0] mw;
      int dones;

      rst = 1'b1; req_valid = 1'b0; use_b = 1'b0; miso = 1'b0;
      req_ra = 3'd0; req_wnr = 1'b0; req_di = 12'd0;

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      chk("rst.a_ready", a_ready, 1); chk("rst.a_ssel", a_ssel, 0); chk("rst.a_sck", a_sck, 0);
      chk("rst.a_mosi", a_mosi, 0);   chk("rst.a_rsp", a_rsp, 0);   chk("rst.a_rv", a_rv, 0);
      chk("rst.a_done", a_done, 0);   chk("rst.b_ready", b_ready, 1); chk("rst.b_ssel", b_ssel, 0);
      chk("rst.b_rsp", b_rsp, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.a_ready", a_ready, 1);
      chk("idle.a_ssel", a_ssel, 0);

      // Write 16'h1DED, D=2.
      mw = 16'($urandom);
      run_frame(2, 3'd0, 1'b1, 12'hDED, mw, 0, 0);
      check_frame("wr", 2, 3'd0, 1'b1, 12'hDED, mw);
      chk("wr.word", r_mosi, 16'h1DED);

      // Read RA=3, slave returns 16'h0A5C.
      run_frame(2, 3'd3, 1'b0, 12'h000, 16'h0A5C, 0, 0);
      check_frame("rd", 2, 3'd3, 1'b0, 12'h000, 16'h0A5C);
      chk("rd.word", r_mosi, 16'h6000);

      // Back-to-back writes with Req_Valid held.
      run_frame(2, 3'd0, 1'b1, 12'hDED, 16'h1234, 1, 0);
      check_frame("b2b1", 2, 3'd0, 1'b1, 12'hDED, 16'h1234);
      run_frame(2, 3'd7, 1'b1, 12'h001, 16'h4321, 0, 0);
      check_frame("b2b2", 2, 3'd7, 1'b1, 12'h001, 16'h4321);
      chk("b2b2.word", r_mosi, 16'hF001);

      // Request fields and Req_Valid change while busy.
      ra = 3'($urandom); wnr = 1'($urandom); di = 12'($urandom);
      run_frame(2, ra, wnr, di, 16'hBA5C, 0, 1);
      check_frame("busy", 2, ra, wnr, di, 16'hBA5C);

      // Reset at cycle 20 of a read.
      req_ra = 3'd3; req_wnr = 1'b0; req_di = 12'h000; req_valid = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
      end
      chk("mid.ssel_before", a_ssel, 1);
      chk("mid.rsp_before", a_rsp, 12'hA5C);
      rst = 1'b1;
      @(negedge clk);
      chk("mid.ssel", a_ssel, 0);   chk("mid.sck", a_sck, 0);   chk("mid.mosi", a_mosi, 0);
      chk("mid.ready", a_ready, 1); chk("mid.rsp", a_rsp, 0);   chk("mid.done", a_done, 0);
      chk("mid.rv", a_rv, 0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (a_done || a_rv || a_ssel) dones++;
      end
      chk("mid.quiet", dones, 0);
      mw = 16'($urandom);
      run_frame(2, 3'd5, 1'b0, 12'h3C3, mw, 0, 0);
      check_frame("after_rst", 2, 3'd5, 1'b0, 12'h3C3, mw);

      // CLK_DIV=1 boundary read with all-ones MISO.
      use_b = 1'b1;
      ra = 3'($urandom);
      run_frame(1, ra, 1'b0, 12'h000, 16'hFFFF, 0, 0);
      check_frame("d1", 1, ra, 1'b0, 12'h000, 16'hFFFF);
      chk("d1.rsp_fff", r_rsp, 12'hFFF);

      // Random frames on both instances with random idle gaps.
      for (int i = 0; i < 8; i++) begin
         use_b = 1'(i & 1);
         ra = 3'($urandom); wnr = 1'($urandom); di = 12'($urandom); mw = 16'($urandom);
         run_frame(use_b ? 1 : 2, ra, wnr, di, mw, 0, 0);
         check_frame($sformatf("rnd%0d", i), use_b ? 1 : 2, ra, wnr, di, mw);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
